// File: rtl/stack_unit_pkg.sv
// Shared encodings for the hardware stack engine: command opcodes,
// sequencer states and small opcode classification helpers.
package stack_unit_pkg;

   // Command opcodes as presented on cmd_op by the control unit
   typedef enum logic [1:0] {
      STACK_OP_PUSH = 2'd0,
      STACK_OP_POP  = 2'd1,
      STACK_OP_CALL = 2'd2,
      STACK_OP_RET  = 2'd3
   } stack_op_e;

   // Transaction sequencer states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_XFER = 2'd1,
      ST_DONE = 2'd2
   } stack_state_e;

   // PUSH and CALL move data into memory and grow the stack downwards
   function automatic logic op_is_write(input stack_op_e op);
      return (op == STACK_OP_PUSH) || (op == STACK_OP_CALL);
   endfunction

   // CALL and RET move a whole return address rather than a single byte
   function automatic logic op_is_multi(input stack_op_e op);
      return (op == STACK_OP_CALL) || (op == STACK_OP_RET);
   endfunction

endpackage

// File: rtl/stack_unit.sv
// Multi-byte stack engine: owns the stack pointer and sequences PUSH, POP,
// CALL and RET as byte-wide memory transactions with a wait-state handshake.
module stack_unit
   import stack_unit_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 16,
   parameter int PC_WIDTH   = 10,
   parameter int SP_WIDTH   = 16,
   parameter logic [SP_WIDTH-1:0] SP_RESET = SP_WIDTH'(16'h00BF),
   parameter logic [SP_WIDTH-1:0] SP_LIMIT = SP_WIDTH'(16'h0040)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [1:0]            cmd_op,
   input  logic [DATA_WIDTH-1:0] cmd_data,
   input  logic [PC_WIDTH-1:0]   cmd_pc,
   output logic                  done,
   output logic                  err,
   output logic [DATA_WIDTH-1:0] pop_data,
   output logic [PC_WIDTH-1:0]   ret_pc,
   output logic [SP_WIDTH-1:0]   sp,
   input  logic                  sp_we,
   input  logic [((SP_WIDTH+DATA_WIDTH-1)/DATA_WIDTH)-1:0] sp_wsel,
   input  logic [DATA_WIDTH-1:0] sp_wdata,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  mem_cs,
   output logic                  mem_we,
   output logic                  mem_oe,
   input  logic                  mem_ack
);

   localparam int PC_BYTES = (PC_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
   localparam int SP_BYTES = (SP_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
   localparam int CNT_W    = (PC_BYTES > 1) ? $clog2(PC_BYTES) : 1;
   // Wide enough that SP plus a byte count never wraps during the bounds check
   localparam int CMP_W    = SP_WIDTH + CNT_W + 2;

   stack_state_e              state_q, state_d;
   stack_op_e                 op_q, op_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0]     data_q, data_d;
   logic [PC_WIDTH-1:0]       pc_q, pc_d;
   logic [SP_WIDTH-1:0]       sp_q, sp_d;
   logic [DATA_WIDTH-1:0]     pop_q, pop_d;
   logic [PC_WIDTH-1:0]       ret_q, ret_d;
   logic                      err_q, err_d;

   stack_op_e                 cmd_op_e;
   logic [CMP_W-1:0]          sp_ext;
   logic [CMP_W-1:0]          n_ext;
   logic                      overflow;
   logic                      underflow;
   logic                      bound_err;
   logic                      is_write;
   logic                      last_byte;
   logic [SP_WIDTH-1:0]       xfer_sp;
   logic [PC_BYTES*DATA_WIDTH-1:0] pc_ext;
   logic [DATA_WIDTH-1:0]     wr_byte;

   // Bounds check for the command being offered, evaluated against the current SP
   always_comb begin
      cmd_op_e  = stack_op_e'(cmd_op);
      sp_ext    = CMP_W'(sp_q);
      n_ext     = op_is_multi(cmd_op_e) ? CMP_W'(PC_BYTES) : CMP_W'(1);
      overflow  = (sp_ext + CMP_W'(1)) < (CMP_W'(SP_LIMIT) + n_ext);
      underflow = (sp_ext + n_ext) > CMP_W'(SP_RESET);
      bound_err = op_is_write(cmd_op_e) ? overflow : underflow;
   end

   // Address and write byte of the transfer in progress; reads pre-increment SP
   always_comb begin
      is_write  = op_is_write(op_q);
      last_byte = !op_is_multi(op_q) || (cnt_q == CNT_W'(PC_BYTES - 1));
      xfer_sp   = is_write ? sp_q : (sp_q + SP_WIDTH'(1));
      pc_ext    = '0;
      pc_ext[PC_WIDTH-1:0] = pc_q;
      wr_byte   = data_q;
      if (op_q == STACK_OP_CALL) begin
         wr_byte = '0;
         for (int k = 0; k < PC_BYTES; k++) begin
            if (cnt_q == CNT_W'(k)) begin
               wr_byte = pc_ext[k*DATA_WIDTH +: DATA_WIDTH];
            end
         end
      end
   end

   // Sequencer next state: SP writes, command acceptance and per-byte transfers
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      pc_d    = pc_q;
      sp_d    = sp_q;
      pop_d   = pop_q;
      ret_d   = ret_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            if (sp_we) begin
               for (int b = 0; b < SP_WIDTH; b++) begin
                  if (sp_wsel[b / DATA_WIDTH]) begin
                     sp_d[b] = sp_wdata[b % DATA_WIDTH];
                  end
               end
            end else if (cmd_valid) begin
               op_d    = cmd_op_e;
               data_d  = cmd_data;
               pc_d    = cmd_pc;
               cnt_d   = '0;
               err_d   = bound_err;
               state_d = bound_err ? ST_DONE : ST_XFER;
            end
         end
         ST_XFER: begin
            if (mem_ack) begin
               sp_d = xfer_sp;
               if (is_write) begin
                  sp_d = sp_q - SP_WIDTH'(1);
               end
               if (op_q == STACK_OP_POP) begin
                  pop_d = mem_rdata;
               end
               if (op_q == STACK_OP_RET) begin
                  for (int b = 0; b < PC_WIDTH; b++) begin
                     if (cnt_q == CNT_W'(PC_BYTES - 1 - b / DATA_WIDTH)) begin
                        ret_d[b] = mem_rdata[b % DATA_WIDTH];
                     end
                  end
               end
               if (last_byte) begin
                  state_d = ST_DONE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers with asynchronous reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         op_q    <= STACK_OP_PUSH;
         cnt_q   <= '0;
         data_q  <= '0;
         pc_q    <= '0;
         sp_q    <= SP_RESET;
         pop_q   <= '0;
         ret_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         pc_q    <= pc_d;
         sp_q    <= sp_d;
         pop_q   <= pop_d;
         ret_q   <= ret_d;
         err_q   <= err_d;
      end
   end

   // Outputs decoded from state so strobes drop the moment reset hits
   always_comb begin
      cmd_ready = (state_q == ST_IDLE) && !sp_we && !reset;
      done      = (state_q == ST_DONE);
      err       = (state_q == ST_DONE) && err_q;
      mem_cs    = (state_q == ST_XFER);
      mem_we    = (state_q == ST_XFER) && is_write;
      mem_oe    = (state_q == ST_XFER) && !is_write;
      mem_addr  = '0;
      mem_wdata = '0;
      if (state_q == ST_XFER) begin
         mem_addr = ADDR_WIDTH'(xfer_sp);
         if (is_write) begin
            mem_wdata = wr_byte;
         end
      end
      pop_data  = pop_q;
      ret_pc    = ret_q;
      sp        = sp_q;
   end

endmodule
